// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared definitions for the exhaustive truth-table checker family.
//   - State encoding of the checker FSM (IDLE/DRIVE/SAMPLE/FINISH).
//   - Width constants for the 4-input variant: N_IN input bits, N_VEC vectors.
//   - Helper function that computes the mismatch flag for one sample.
// -----------------------------------------------------------------------------
package tt_pkg;

    localparam int N_IN  = 4;
    localparam int N_VEC = 16;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_DRIVE_ENC  = 2'd1;
    localparam logic [1:0] ST_SAMPLE_ENC = 2'd2;
    localparam logic [1:0] ST_FINISH_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_DRIVE  = ST_DRIVE_ENC,
        ST_SAMPLE = ST_SAMPLE_ENC,
        ST_FINISH = ST_FINISH_ENC
    } tt_state_t;

    // High when the observed DUT output disagrees with the expected bit.
    function automatic logic tt_mismatch(input logic observed, input logic expected);
        return observed ^ expected;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_settle_timer
// 4-bit down-counter that paces how long a stimulus vector is held.
// Loading N makes expire rise after N further cycles (immediately for N=0),
// so loading SETTLE-1 yields a hold of exactly SETTLE cycles.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (count -> 0)
//   load     - load load_val into the counter this edge
//   load_val - value to load
//   expire   - count has reached zero
// -----------------------------------------------------------------------------
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expire
);

    logic [3:0] r_count;

    // Count register: load has priority, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign expire = (r_count == 4'd0);

endmodule

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
// Sweeps all 16 input combinations {a,b,c,d} (a = MSB) into a 4-input
// combinational DUT, samples its output o after SETTLE cycles per vector,
// builds the observed truth table and compares it against EXPECTED.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - begin a sweep (only honoured in IDLE)
//   o             - DUT output (assumed synchronous to clk)
//   a, b, c, d    - DUT inputs, the registered vector index
//   busy          - sweep in progress
//   done          - one-cycle end-of-sweep pulse
//   pass          - verdict, valid from done until next accepted start
//   table_out     - captured truth table
//   mismatch_cnt  - number of mismatching indices (0..16)
//   first_bad     - lowest mismatching index (0 if none)
// -----------------------------------------------------------------------------
module truth_table_checker
    import tt_pkg::*;
#(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int          SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        o,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_bad
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

    tt_state_t         r_state;
    tt_state_t         w_next_state;
    logic [N_IN-1:0]   r_idx;
    logic [N_VEC-1:0]  r_table;
    logic [4:0]        r_mis_cnt;
    logic [3:0]        r_first_bad;
    logic              r_pass;
    logic              r_busy;
    logic              r_done;
    logic              w_timer_load;
    logic              w_expire;
    logic              w_mis;

    tt_settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_timer_load),
        .load_val (SETTLE_LOAD),
        .expire   (w_expire)
    );

    assign w_mis = tt_mismatch(o, EXPECTED[r_idx]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and timer load requests.
    always_comb begin
        w_next_state = r_state;
        w_timer_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_DRIVE;
                    w_timer_load = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (w_expire) begin
                    w_next_state = ST_SAMPLE;
                end else begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_state = ST_DRIVE;
                    w_timer_load = 1'b1;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: vector index, captured table, mismatch bookkeeping, flags.
    // busy/done are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_table     <= '0;
            r_mis_cnt   <= 5'd0;
            r_first_bad <= 4'd0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (w_next_state == ST_FINISH);
            r_busy <= (w_next_state == ST_DRIVE) || (w_next_state == ST_SAMPLE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_table     <= '0;
                        r_mis_cnt   <= 5'd0;
                        r_first_bad <= 4'd0;
                        r_pass      <= 1'b0;
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_SAMPLE: begin
                    r_table[r_idx] <= o;
                    if (w_mis) begin
                        r_mis_cnt <= r_mis_cnt + 5'd1;
                        if (r_mis_cnt == 5'd0) begin
                            r_first_bad <= r_idx;
                        end else begin
                            r_first_bad <= r_first_bad;
                        end
                    end else begin
                        r_mis_cnt <= r_mis_cnt;
                    end
                    if (r_idx == LAST_IDX) begin
                        // Verdict must include the sample taken on this edge.
                        r_pass <= (r_mis_cnt == 5'd0) && !w_mis;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign {a, b, c, d}  = r_idx;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign table_out     = r_table;
    assign mismatch_cnt  = r_mis_cnt;
    assign first_bad     = r_first_bad;

endmodule
